// File: rtl/uart_pkg.sv
// Shared definitions for the APB-readable UART receiver: register map, status layout,
// receiver FSM states and baud divider helper.
package uart_pkg;

  localparam logic [31:0] RxDataOffset = 32'h0;
  localparam logic [31:0] StatusOffset = 32'h4;

  localparam int unsigned StatusNotEmptyBit = 0;
  localparam int unsigned StatusFullBit     = 1;
  localparam int unsigned StatusOvrBit      = 2;
  localparam int unsigned StatusFerrBit     = 3;
  localparam int unsigned StatusLevelLsb    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous RX FIFO. A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  localparam int unsigned Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [Aw:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (Aw+1)'(Depth));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level counter guards every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_apb.sv
// 8N1 UART receiver feeding an RX FIFO, drained over APB3 via RXDATA (pop) and STATUS
// (sticky OVR/FERR, cleared on read).
module uart_rx_apb
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 30000000,
  parameter int unsigned UART_BPS   = 921600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  output logic        in_pready,
  output logic        in_pslverr,
  input  logic [31:0] in_paddr,
  input  logic        in_pwrite,
  output logic [31:0] in_prdata,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  input  logic        uart_rx,
  output logic        rx_irq
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, UART_BPS);
  localparam int unsigned CntW = $clog2(Div);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntHalf = CntW'(Div / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  logic [1:0]      sync_q, sync_d;
  logic            rxs, rxs_prev_q, rxs_prev_d;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
  logic            push_req, set_ferr, set_ovr;
  logic            rd_access, rd_rxdata, rd_status, pop;
  logic [7:0]      fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic [LvlW-1:0] fifo_level;
  logic [31:0]     status;
  logic            unused_inputs;

  assign unused_inputs = ^{in_pprot, in_pwdata, in_pstrb, in_paddr[31:4], in_paddr[1:0]};

  assign sync_d     = {sync_q[0], uart_rx};
  assign rxs        = sync_q[1];
  assign rxs_prev_d = rxs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      sync_q     <= sync_d;
      rxs_prev_q <= rxs_prev_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        // Return to idle at mid-stop so the next start edge is never missed.
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    push_req = 1'b0;
    set_ferr = 1'b0;
    if (state_q == StStop && cnt_q == CntLast) begin
      if (rxs) push_req = 1'b1;
      else     set_ferr = 1'b1;
    end
  end

  assign rd_access = in_psel & in_penable & ~in_pwrite;
  assign rd_rxdata = rd_access & (in_paddr[3:2] == RxDataOffset[3:2]);
  assign rd_status = rd_access & (in_paddr[3:2] == StatusOffset[3:2]);
  assign pop       = rd_rxdata & ~fifo_empty;
  assign set_ovr   = push_req & fifo_full & ~pop;

  uart_rx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (push_req),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Clear-on-read first so a same-cycle error wins.
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (rd_status) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (set_ovr)  ovr_d  = 1'b1;
    if (set_ferr) ferr_d = 1'b1;
    irq_d = ~fifo_empty;
  end

  always_comb begin
    status                                = '0;
    status[StatusNotEmptyBit]             = ~fifo_empty;
    status[StatusFullBit]                 = fifo_full;
    status[StatusOvrBit]                  = ovr_q;
    status[StatusFerrBit]                 = ferr_q;
    status[StatusLevelLsb +: 8]           = 8'(fifo_level);
  end

  always_comb begin
    in_prdata = '0;
    if (rd_rxdata && !fifo_empty) begin
      in_prdata = {24'b0, fifo_rdata};
    end else if (rd_status) begin
      in_prdata = status;
    end
  end

  assign in_pready  = 1'b1;
  assign in_pslverr = 1'b0;
  assign rx_irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_apb.sv
// Directed bench for uart_rx_apb: single byte, glitch, framing error, overrun,
// empty read, push/pop collision while full, and reset mid-frame.
module tb_uart_rx_apb;

  localparam int unsigned BitClk = 32;
  localparam logic [31:0] AddrData = 32'h0;
  localparam logic [31:0] AddrStat = 32'h4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic [2:0]  in_pprot = 3'b0;
  logic        in_pready;
  logic        in_pslverr;
  logic [31:0] in_paddr = 32'h0;
  logic        in_pwrite = 1'b0;
  logic [31:0] in_prdata;
  logic [31:0] in_pwdata = 32'h0;
  logic [3:0]  in_pstrb = 4'h0;
  logic        uart_rx = 1'b1;
  logic        rx_irq;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  uart_rx_apb dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_psel    (in_psel),
    .in_penable (in_penable),
    .in_pprot   (in_pprot),
    .in_pready  (in_pready),
    .in_pslverr (in_pslverr),
    .in_paddr   (in_paddr),
    .in_pwrite  (in_pwrite),
    .in_prdata  (in_prdata),
    .in_pwdata  (in_pwdata),
    .in_pstrb   (in_pstrb),
    .uart_rx    (uart_rx),
    .rx_irq     (rx_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    in_psel = 1'b1; in_penable = 1'b0; in_paddr = addr; in_pwrite = 1'b0;
    @(negedge clk);
    in_penable = 1'b1;
    #1 data = in_prdata;
    @(negedge clk);
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    in_psel = 1'b1; in_penable = 1'b0; in_paddr = addr; in_pwrite = 1'b1; in_pwdata = data;
    @(negedge clk);
    in_penable = 1'b1;
    @(negedge clk);
    in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BitClk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BitClk) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BitClk) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pready", {31'b0, in_pready}, 32'h1);
    check("reset_pslverr", {31'b0, in_pslverr}, 32'h0);
    check("reset_prdata", in_prdata, 32'h0);
    check("reset_irq", {31'b0, rx_irq}, 32'h0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    apb_read(AddrStat, rd); check("reset_status", rd, 32'h0);

    // Single byte
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("a5_irq_high", {31'b0, rx_irq}, 32'h1);
    apb_write(AddrData, 32'hFFFF_FFFF);
    apb_read(32'h8, rd); check("reg8_zero", rd, 32'h0);
    apb_read(32'hC, rd); check("regc_zero", rd, 32'h0);
    apb_read(AddrStat, rd); check("a5_status", rd, 32'h0000_0101);
    apb_read(AddrData, rd); check("a5_data", rd, 32'h0000_00A5);
    apb_read(AddrStat, rd); check("a5_status_after", rd, 32'h0);
    repeat (2) @(negedge clk);
    check("a5_irq_low", {31'b0, rx_irq}, 32'h0);

    // Glitch rejection
    @(negedge clk); uart_rx = 1'b0;
    repeat (10) @(negedge clk); uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    apb_read(AddrStat, rd); check("glitch_status", rd, 32'h0);
    send_byte(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    apb_read(AddrData, rd); check("glitch_next_data", rd, 32'h0000_003C);

    // Framing error
    send_byte(8'h55, 1'b0);
    repeat (BitClk) @(negedge clk);
    apb_read(AddrStat, rd); check("ferr_status", rd, 32'h0000_0008);
    apb_read(AddrStat, rd); check("ferr_cleared", rd, 32'h0);

    // Overrun: 17 bytes, 0x10 dropped
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    apb_read(AddrStat, rd); check("ovr_status", rd, 32'h0000_1007);
    for (int i = 0; i < 16; i++) begin
      apb_read(AddrData, rd); check($sformatf("ovr_data%0d", i), rd, 32'(i));
    end
    apb_read(AddrStat, rd); check("ovr_drained", rd, 32'h0);

    // Empty read
    apb_read(AddrData, rd); check("empty_data", rd, 32'h0);
    apb_read(AddrStat, rd); check("empty_level", rd, 32'h0);

    // Pop coincident with the stop-sample push while full
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    apb_read(AddrStat, rd); check("full_status", rd, 32'h0000_1003);
    fork
      send_byte(8'h77, 1'b1);
      begin
        // Stop sample lands on the 307th rising edge after the start-bit negedge.
        @(negedge clk);
        repeat (305) @(posedge clk);
        @(negedge clk);
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = AddrData; in_pwrite = 1'b0;
        @(negedge clk);
        in_penable = 1'b1;
        #1 check("sim_pop_data", in_prdata, 32'h0);
        @(negedge clk);
        in_psel = 1'b0; in_penable = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    apb_read(AddrStat, rd); check("sim_status", rd, 32'h0000_1003);
    for (int i = 1; i < 16; i++) begin
      apb_read(AddrData, rd); check($sformatf("sim_data%0d", i), rd, 32'(i));
    end
    apb_read(AddrData, rd); check("sim_data_last", rd, 32'h0000_0077);
    apb_read(AddrStat, rd); check("sim_drained", rd, 32'h0);

    // Reset during bit 4 of 0xF0; a byte already queued must also be cleared
    send_byte(8'h42, 1'b1);
    @(negedge clk); uart_rx = 1'b0;
    repeat (BitClk) @(negedge clk);
    repeat (4 * BitClk) @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk); resetn = 1'b0;
    repeat (3) @(negedge clk); resetn = 1'b1;
    repeat (19 + 4 * BitClk) @(negedge clk);
    check("rst_irq_clear", {31'b0, rx_irq}, 32'h0);
    send_byte(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    apb_read(AddrStat, rd); check("rst_status", rd, 32'h0000_0101);
    apb_read(AddrData, rd); check("rst_data", rd, 32'h0000_0081);
    apb_read(AddrStat, rd); check("rst_status_after", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
